// File: rtl/toggle_ramp_pkg.sv
// toggle_ramp_pkg: shared state encoding and default widths for the toggle-rate ramp controller
package toggle_ramp_pkg;
  localparam int RATE_W_DEF   = 7;
  localparam int MAX_RATE_DEF = 99;
  localparam int STEP_W_DEF   = 4;
  localparam int DWELL_W_DEF  = 16;
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_e;
endpackage

// File: rtl/ramp_dwell_timer.sv
// ramp_dwell_timer: loadable down-counter that flags when the dwell between ramp steps has elapsed
module ramp_dwell_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk)
    if (rst || clr) cnt_q <= '0;
    else if (load) cnt_q <= load_val;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/toggle_rate_ramp.sv
// toggle_rate_ramp: ramps the DSP toggle rate toward a requested target in bounded, dwell-spaced steps
module toggle_rate_ramp
  import toggle_ramp_pkg::*;
#(
  parameter int RATE_W   = RATE_W_DEF,
  parameter int MAX_RATE = MAX_RATE_DEF,
  parameter int STEP_W   = STEP_W_DEF,
  parameter int DWELL_W  = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tgt_valid,
  output logic               tgt_ready,
  input  logic [RATE_W-1:0]  tgt_rate,
  input  logic [STEP_W-1:0]  step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               abort,
  output logic [RATE_W-1:0]  toggle_rate,
  output logic               busy,
  output logic               at_target,
  output logic               clamped
);
  localparam logic [RATE_W-1:0] MAXR = RATE_W'(MAX_RATE);
  state_e               state_q, state_d;
  logic [RATE_W-1:0]    cur_q, cur_d, tgt_q, tgt_d, tin, cur_n, delta_n;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 clamped_q, clamped_d, busy_q, busy_d, at_q, at_d;
  logic                 accept, load, zero;
  logic [RATE_W:0]      diff, stp, delta;
  assign tgt_ready = (state_q == IDLE) && !abort;
  assign accept    = tgt_valid && tgt_ready;
  assign tin       = tgt_rate > MAXR ? MAXR : tgt_rate;
  // one extra bit keeps the distance and step comparison free of wraparound
  assign diff    = state_q == UP ? {1'b0, tgt_q} - {1'b0, cur_q} : {1'b0, cur_q} - {1'b0, tgt_q};
  assign stp     = (RATE_W+1)'(step_q);
  assign delta   = stp < diff ? stp : diff;
  assign delta_n = RATE_W'(delta);
  assign cur_n   = state_q == UP ? cur_q + delta_n : cur_q - delta_n;
  ramp_dwell_timer #(.W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (abort),
    .load     (load),
    .load_val (accept ? dwell : dwell_q),
    .zero     (zero)
  );
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    tgt_d     = tgt_q;
    step_d    = step_q;
    dwell_d   = dwell_q;
    clamped_d = clamped_q;
    busy_d    = busy_q;
    at_d      = at_q;
    load      = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cur_d   = '0;
      tgt_d   = '0;
      busy_d  = 1'b0;
      at_d    = 1'b1;
    end else if (accept) begin
      tgt_d     = tin;
      step_d    = step == '0 ? STEP_W'(1) : step;
      dwell_d   = dwell;
      clamped_d = tgt_rate > MAXR;
      state_d   = tin > cur_q ? UP : tin < cur_q ? DOWN : IDLE;
      busy_d    = tin != cur_q;
      at_d      = tin == cur_q;
      load      = 1'b1;
    end else if (state_q != IDLE && zero) begin
      cur_d   = cur_n;
      load    = 1'b1;
      state_d = cur_n == tgt_q ? IDLE : state_q;
      busy_d  = cur_n != tgt_q;
      at_d    = cur_n == tgt_q;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      tgt_q     <= '0;
      step_q    <= STEP_W'(1);
      dwell_q   <= '0;
      clamped_q <= 1'b0;
      busy_q    <= 1'b0;
      at_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
      step_q    <= step_d;
      dwell_q   <= dwell_d;
      clamped_q <= clamped_d;
      busy_q    <= busy_d;
      at_q      <= at_d;
    end
  assign toggle_rate = cur_q;
  assign busy        = busy_q;
  assign at_target   = at_q;
  assign clamped     = clamped_q;
endmodule

// File: tb/tb_toggle_rate_ramp.sv
// tb_toggle_rate_ramp: directed and random ramps checked against a step-schedule reference model
module tb_toggle_rate_ramp;
  logic        clk = 0, rst = 1, tgt_valid = 0, abort = 0;
  logic [6:0]  tgt_rate = 0;
  logic [3:0]  step = 0;
  logic [15:0] dwell = 0;
  logic        tgt_ready, busy, at_target, clamped;
  logic [6:0]  toggle_rate;
  int total = 0, bad = 0;
  int m_cur = 0, m_clamped = 0;

  toggle_rate_ramp dut (
    .clk         (clk),
    .rst         (rst),
    .tgt_valid   (tgt_valid),
    .tgt_ready   (tgt_ready),
    .tgt_rate    (tgt_rate),
    .step        (step),
    .dwell       (dwell),
    .abort       (abort),
    .toggle_rate (toggle_rate),
    .busy        (busy),
    .at_target   (at_target),
    .clamped     (clamped)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Builds the list of rates the ramp must visit, then checks every edge against the schedule.
  task automatic do_ramp(input int t, input int s, input int d);
    int tc, sc, v, n, len, idx;
    int seq[$];
    tc = t > 99 ? 99 : t;
    sc = s == 0 ? 1 : s;
    v = m_cur;
    while (v != tc) begin
      n = tc > v ? tc - v : v - tc;
      if (n > sc) n = sc;
      v = tc > v ? v + n : v - n;
      seq.push_back(v);
    end
    len = seq.size();
    tgt_rate = 7'(t); step = 4'(s); dwell = 16'(d); tgt_valid = 1;
    for (int i = 0; !tgt_ready && i < 100; i++) tick;
    chk("ready_before_accept", tgt_ready, 1);
    tick;
    tgt_valid = 0;
    chk("clamped_on_accept", clamped, t > 99);
    chk("busy_on_accept", busy, len != 0);
    chk("at_target_on_accept", at_target, len == 0);
    chk("ready_after_accept", tgt_ready, len == 0);
    for (int k = 1; k <= len * (d + 1); k++) begin
      tick;
      idx = k / (d + 1) - 1;
      chk("rate", toggle_rate, idx < 0 ? m_cur : seq[idx]);
      chk("busy", busy, k != len * (d + 1));
      chk("at_target", at_target, k == len * (d + 1));
      chk("ready", tgt_ready, k == len * (d + 1));
    end
    m_cur = tc;
    m_clamped = t > 99;
  endtask

  initial begin
    tick;
    tick;
    rst = 0;
    #1;
    chk("rst_rate", toggle_rate, 0);
    chk("rst_ready", tgt_ready, 1);
    chk("rst_at_target", at_target, 1);
    chk("rst_busy", busy, 0);
    chk("rst_clamped", clamped, 0);

    do_ramp(40, 10, 3);
    do_ramp(5, 8, 0);
    do_ramp(0, 15, 0);
    do_ramp(120, 15, 0);
    chk("clamp_final_rate", toggle_rate, 99);
    chk("clamp_flag", clamped, 1);
    do_ramp(50, 15, 0);
    chk("clamp_cleared", clamped, 0);

    do_ramp(0, 15, 0);
    tgt_rate = 80; step = 10; dwell = 0; tgt_valid = 1;
    tick;
    tgt_valid = 0;
    tick;
    tick;
    tick;
    chk("pre_abort_rate", toggle_rate, 30);
    abort = 1; tgt_valid = 1; tgt_rate = 50;
    #1;
    chk("abort_ready_low", tgt_ready, 0);
    tick;
    chk("abort_rate", toggle_rate, 0);
    chk("abort_busy", busy, 0);
    chk("abort_at_target", at_target, 1);
    chk("abort_ready", tgt_ready, 0);
    chk("abort_clamped_held", clamped, m_clamped);
    tick;
    chk("abort_no_accept_rate", toggle_rate, 0);
    chk("abort_no_accept_busy", busy, 0);
    abort = 0; tgt_valid = 0;
    #1;
    chk("post_abort_ready", tgt_ready, 1);
    m_cur = 0;

    do_ramp(m_cur + 3, 0, 0);
    do_ramp(m_cur, 4, 2);
    tick;
    chk("equal_busy_stays", busy, 0);
    chk("equal_at_target_stays", at_target, 1);

    for (int r = 0; r < 10; r++)
      do_ramp(int'($urandom_range(0, 127)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));

    tgt_rate = 7'(m_cur > 50 ? 10 : 90); step = 3; dwell = 1; tgt_valid = 1;
    tick;
    tgt_valid = 0;
    tick;
    tick;
    tick;
    rst = 1;
    tick;
    rst = 0;
    #1;
    chk("midrst_rate", toggle_rate, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_at_target", at_target, 1);
    chk("midrst_clamped", clamped, 0);
    chk("midrst_ready", tgt_ready, 1);
    m_cur = 0;
    do_ramp(7, 2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
